// File: rtl/atm_pkg.sv
// ---------------------------------------------------------------------------
// atm_pkg
// Shared types and constants for the ATM keypad front-end.
//   estado_e    : keypad scanner FSM states
//   KEY_*       : non-digit key codes (digits are coded 0-9)
//   KEYMAP      : 4x4 keypad map, indexed by {row, col}
//   MONTO_W     : width of the committed amount
//   una_fila    : true when exactly one row line is low
//   indice_fila : index of the low row line
// ---------------------------------------------------------------------------
package atm_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StEmit,
        StWaitRelease
    } estado_e;

    localparam int unsigned MONTO_W = 32;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Element {row, col}; element 0 (row 0, col 0) is the rightmost entry.
    localparam logic [15:0][3:0] KEYMAP = {
        KEY_D, KEY_HASH, 4'h0, KEY_STAR,
        KEY_C, 4'h9,     4'h8, 4'h7,
        KEY_B, 4'h6,     4'h5, 4'h4,
        KEY_A, 4'h3,     4'h2, 4'h1
    };

    // Rows are active-low: a single key shows up as exactly one zero bit.
    function automatic logic una_fila(input logic [3:0] filas);
        return $onehot(~filas);
    endfunction

    function automatic logic [1:0] indice_fila(input logic [3:0] filas);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!filas[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sincronizador_filas.sv
// ---------------------------------------------------------------------------
// sincronizador_filas
// Two-flop synchroniser for the asynchronous keypad row lines.
//   i_clk     : system clock
//   i_reset_n : synchronous active-low reset, flops reset to 4'hF (no key)
//   i_filas   : raw active-low row lines
//   o_filas   : synchronised row lines
// ---------------------------------------------------------------------------
module sincronizador_filas (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [3:0] i_filas,
    output logic [3:0] o_filas
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_meta <= 4'hF;
            r_sync <= 4'hF;
        end else begin
            r_meta <= i_filas;
            r_sync <= r_meta;
        end
    end

    assign o_filas = r_sync;

endmodule

// File: rtl/teclado_entrada.sv
// ---------------------------------------------------------------------------
// teclado_entrada
// Keypad front-end of the ATM controller: scans a 4x4 matrix keypad,
// debounces presses and releases, and turns each press into either a PIN
// digit strobe or an amount-entry action.
//   i_clk        : system clock, rising edge
//   i_reset_n    : synchronous active-low reset
//   i_filas      : keypad rows, asynchronous, active-low
//   o_columnas   : keypad column drive, active-low, exactly one column low
//   i_modo_monto : 0 = PIN digit mode, 1 = amount mode
//   o_digito     : last digit (0-9), held
//   o_digito_stb : one-cycle pulse, o_digito valid
//   o_monto      : last committed amount, binary, held
//   o_monto_stb  : one-cycle pulse, o_monto valid
// ---------------------------------------------------------------------------
module teclado_entrada
    import atm_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned MAX_DIGITS      = 9
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [3:0]         i_filas,
    output logic [3:0]         o_columnas,
    input  logic               i_modo_monto,
    output logic [3:0]         o_digito,
    output logic               o_digito_stb,
    output logic [MONTO_W-1:0] o_monto,
    output logic               o_monto_stb
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > SCAN_CYCLES) ? DEBOUNCE_CYCLES
                                                                     : SCAN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned NDIG_W  = $clog2(MAX_DIGITS + 1);

    localparam logic [CNT_W-1:0]  SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_UNO   = CNT_W'(1);
    localparam logic [NDIG_W-1:0] NDIG_MAX  = NDIG_W'(MAX_DIGITS);
    localparam logic [NDIG_W-1:0] NDIG_UNO  = NDIG_W'(1);

    // State
    estado_e             r_state;
    logic [1:0]          r_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_col;
    logic [3:0]          r_rows;
    logic [3:0]          r_digito;
    logic                r_digito_stb;
    logic [MONTO_W-1:0]  r_monto;
    logic                r_monto_stb;
    logic [MONTO_W-1:0]  r_acc;
    logic [NDIG_W-1:0]   r_ndig;
    logic                r_modo_q;
    logic                r_modo_prev;

    // Next state
    estado_e             w_state_d;
    logic [1:0]          w_idx_d;
    logic [CNT_W-1:0]    w_cnt_d;
    logic [1:0]          w_col_d;
    logic [3:0]          w_rows_d;
    logic [3:0]          w_digito_d;
    logic                w_digito_stb_d;
    logic [MONTO_W-1:0]  w_monto_d;
    logic                w_monto_stb_d;
    logic [MONTO_W-1:0]  w_acc_d;
    logic [NDIG_W-1:0]   w_ndig_d;

    logic [3:0]          w_f;
    logic [3:0]          w_key;
    logic                w_modo_flanco;

    sincronizador_filas u_sincronizador_filas (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_filas   (i_filas),
        .o_filas   (w_f)
    );

    assign w_key         = KEYMAP[{indice_fila(r_rows), r_col}];
    assign w_modo_flanco = r_modo_q ^ r_modo_prev;

    always_comb begin
        w_state_d      = r_state;
        w_idx_d        = r_idx;
        w_cnt_d        = r_cnt;
        w_col_d        = r_col;
        w_rows_d       = r_rows;
        w_digito_d     = r_digito;
        w_digito_stb_d = 1'b0;
        w_monto_d      = r_monto;
        w_monto_stb_d  = 1'b0;
        w_acc_d        = r_acc;
        w_ndig_d       = r_ndig;

        unique case (r_state)
            StScan: begin
                // Rows are only inspected on the last cycle of a column, by
                // which time the synchroniser reflects this column's drive.
                if (r_cnt == SCAN_LAST) begin
                    w_cnt_d = '0;
                    if (w_f != 4'hF) begin
                        w_col_d   = r_idx;
                        w_rows_d  = w_f;
                        w_state_d = StDebounce;
                    end else begin
                        w_idx_d = r_idx + 2'd1;
                    end
                end else begin
                    w_cnt_d = r_cnt + CNT_UNO;
                end
            end

            StDebounce: begin
                if (w_f != r_rows) begin
                    w_state_d = StScan;
                    w_idx_d   = r_idx + 2'd1;
                    w_cnt_d   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_cnt_d   = '0;
                    // Multi-key presses are swallowed but still need a release.
                    w_state_d = una_fila(r_rows) ? StEmit : StWaitRelease;
                end else begin
                    w_cnt_d = r_cnt + CNT_UNO;
                end
            end

            StEmit: begin
                w_state_d = StWaitRelease;
                w_cnt_d   = '0;
                // A mode change in the same cycle drops the key.
                if (!w_modo_flanco) begin
                    if (!r_modo_q) begin
                        if (w_key <= 4'd9) begin
                            w_digito_d     = w_key;
                            w_digito_stb_d = 1'b1;
                        end
                    end else if (w_key <= 4'd9) begin
                        if (r_ndig < NDIG_MAX) begin
                            w_acc_d  = (r_acc * MONTO_W'(10)) + MONTO_W'(w_key);
                            w_ndig_d = r_ndig + NDIG_UNO;
                        end
                    end else if (w_key == KEY_STAR) begin
                        w_acc_d  = '0;
                        w_ndig_d = '0;
                    end else if (w_key == KEY_HASH && r_ndig != '0) begin
                        w_monto_d     = r_acc;
                        w_monto_stb_d = 1'b1;
                        w_acc_d       = '0;
                        w_ndig_d      = '0;
                    end
                end
            end

            StWaitRelease: begin
                if (w_f != 4'hF) begin
                    w_cnt_d = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_d = StScan;
                    w_idx_d   = r_idx + 2'd1;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_UNO;
                end
            end

            default: begin
                w_state_d = StScan;
                w_cnt_d   = '0;
            end
        endcase

        if (w_modo_flanco) begin
            w_acc_d  = '0;
            w_ndig_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= StScan;
            r_idx        <= 2'd0;
            r_cnt        <= '0;
            r_col        <= 2'd0;
            r_rows       <= 4'hF;
            r_digito     <= 4'd0;
            r_digito_stb <= 1'b0;
            r_monto      <= '0;
            r_monto_stb  <= 1'b0;
            r_acc        <= '0;
            r_ndig       <= '0;
            r_modo_q     <= 1'b0;
            r_modo_prev  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_idx        <= w_idx_d;
            r_cnt        <= w_cnt_d;
            r_col        <= w_col_d;
            r_rows       <= w_rows_d;
            r_digito     <= w_digito_d;
            r_digito_stb <= w_digito_stb_d;
            r_monto      <= w_monto_d;
            r_monto_stb  <= w_monto_stb_d;
            r_acc        <= w_acc_d;
            r_ndig       <= w_ndig_d;
            r_modo_q     <= i_modo_monto;
            r_modo_prev  <= r_modo_q;
        end
    end

    // The column index is frozen outside scanning, so the pressed column
    // stays driven through debounce and release.
    assign o_columnas   = ~(4'b0001 << r_idx);
    assign o_digito     = r_digito;
    assign o_digito_stb = r_digito_stb;
    assign o_monto      = r_monto;
    assign o_monto_stb  = r_monto_stb;

endmodule
